// File: rtl/memory_access.sv
// Memory pipeline stage: issues loads/stores on a command/ack + read-data bus and stalls the core while busy.
// Optional `MEMORY_ACCESS_ALIGN_CHECK_EN adds misaligned-access detection with an o_addr_err pulse.
`ifndef CPU_ADDR_WIDTH
`define CPU_ADDR_WIDTH  32
`define CPU_DATA_WIDTH  32
`define CPU_REG_WIDTH   32
`define CPU_REGNO_WIDTH 5
`define CPU_LSUOP_WIDTH 2
`define CPU_LSU_IDLE    2'd0
`define CPU_LSU_BYTE    2'd1
`define CPU_LSU_HWORD   2'd2
`define CPU_LSU_WORD    2'd3
`endif

module memory_access (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          i_exec_stall,
  input  logic                          i_fetch_stall,
  input  logic [`CPU_REGNO_WIDTH-1:0]   i_rd_no,
  input  logic [`CPU_REG_WIDTH-1:0]     i_alu_result,
  input  logic [`CPU_LSUOP_WIDTH-1:0]   i_lsu_op,
  input  logic                          i_lsu_lns,
  input  logic                          i_lsu_ext,
  input  logic [`CPU_DATA_WIDTH-1:0]    i_mem_data,
  output logic                          o_mem_stall,
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
  output logic                          o_addr_err,
`endif
  output logic [`CPU_REGNO_WIDTH-1:0]   o_rd_no,
  output logic [`CPU_REG_WIDTH-1:0]     o_rd_val,
  output logic [`CPU_ADDR_WIDTH-1:0]    o_bus_addr,
  output logic                          o_bus_cmd,
  output logic                          o_bus_wr,
  output logic [3:0]                    o_bus_ben,
  output logic [`CPU_DATA_WIDTH-1:0]    o_bus_wdata,
  input  logic                          i_bus_ack,
  input  logic [`CPU_DATA_WIDTH-1:0]    i_bus_rdata,
  input  logic                          i_bus_rdata_valid
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  state_t                        r_state;
  logic [`CPU_LSUOP_WIDTH-1:0]   r_op;
  logic [1:0]                    r_lo;
  logic                          r_ext;
  logic                          r_lns;
  logic                          r_err;
  logic [`CPU_REG_WIDTH-1:0]     r_load;
  logic                          w_mem_op;
  logic                          w_misal;
  logic                          w_core_stall;

  function automatic logic [3:0] f_ben(input logic [`CPU_LSUOP_WIDTH-1:0] op, input logic [1:0] lo);
    case (op)
      `CPU_LSU_BYTE:  f_ben = 4'b0001 << lo;
      `CPU_LSU_HWORD: f_ben = lo[1] ? 4'b1100 : 4'b0011;
      default:        f_ben = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [`CPU_LSUOP_WIDTH-1:0] op, input logic [31:0] d);
    case (op)
      `CPU_LSU_BYTE:  f_wdata = {4{d[7:0]}};
      `CPU_LSU_HWORD: f_wdata = {2{d[15:0]}};
      default:        f_wdata = d;
    endcase
  endfunction

  // Lane select then sign/zero extension of the returned bus word.
  function automatic logic [31:0] f_extract(input logic [`CPU_LSUOP_WIDTH-1:0] op, input logic [1:0] lo,
                                            input logic ext, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (op)
      `CPU_LSU_BYTE:  f_extract = {{24{ext & b[7]}}, b};
      `CPU_LSU_HWORD: f_extract = {{16{ext & h[15]}}, h};
      default:        f_extract = d;
    endcase
  endfunction

  assign w_mem_op = (i_lsu_op != `CPU_LSU_IDLE);
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
  assign w_misal = ((i_lsu_op == `CPU_LSU_HWORD) && i_alu_result[0]) ||
                   ((i_lsu_op == `CPU_LSU_WORD) && (i_alu_result[1:0] != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  assign o_mem_stall  = ((r_state == IDLE) && w_mem_op) || (r_state == CMD) || (r_state == WAIT);
  assign w_core_stall = i_exec_stall | i_fetch_stall | o_mem_stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_op        <= `CPU_LSU_IDLE;
      r_lo        <= 2'b00;
      r_ext       <= 1'b0;
      r_lns       <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= '0;
      o_rd_no     <= '0;
      o_rd_val    <= '0;
      o_bus_addr  <= '0;
      o_bus_cmd   <= 1'b0;
      o_bus_wr    <= 1'b0;
      o_bus_ben   <= 4'b0000;
      o_bus_wdata <= '0;
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
      o_addr_err  <= 1'b0;
`endif
    end else begin
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
      o_addr_err <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_mem_op) begin
          r_op  <= i_lsu_op;
          r_lo  <= i_alu_result[1:0];
          r_ext <= i_lsu_ext;
          r_lns <= i_lsu_lns;
          r_err <= w_misal;
          if (w_misal) begin
            r_state <= DONE;
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
            o_addr_err <= 1'b1;
`endif
          end else begin
            r_state     <= CMD;
            o_bus_cmd   <= 1'b1;
            o_bus_addr  <= {i_alu_result[`CPU_ADDR_WIDTH-1:2], 2'b00};
            o_bus_wr    <= ~i_lsu_lns;
            o_bus_ben   <= f_ben(i_lsu_op, i_alu_result[1:0]);
            o_bus_wdata <= f_wdata(i_lsu_op, i_mem_data);
          end
        end
        CMD: if (i_bus_ack) begin
          o_bus_cmd <= 1'b0;
          if (!r_lns) begin
            r_state <= DONE;
          end else if (i_bus_rdata_valid) begin
            r_load  <= f_extract(r_op, r_lo, r_ext, i_bus_rdata);
            r_state <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: if (i_bus_rdata_valid) begin
          r_load  <= f_extract(r_op, r_lo, r_ext, i_bus_rdata);
          r_state <= DONE;
        end
        DONE: if (!(i_exec_stall | i_fetch_stall)) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Writeback: outside DONE an unstalled cycle can only be a non-memory op.
      if (!w_core_stall) begin
        if (r_state == DONE) begin
          if (r_lns && !r_err) begin
            o_rd_no  <= i_rd_no;
            o_rd_val <= r_load;
          end else begin
            o_rd_no  <= '0;
            o_rd_val <= '0;
          end
        end else begin
          o_rd_no  <= i_rd_no;
          o_rd_val <= i_alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed table-driven bench for memory_access, with hand sequences for stalls, reset and alignment.
`ifndef CPU_ADDR_WIDTH
`define CPU_ADDR_WIDTH  32
`define CPU_DATA_WIDTH  32
`define CPU_REG_WIDTH   32
`define CPU_REGNO_WIDTH 5
`define CPU_LSUOP_WIDTH 2
`define CPU_LSU_IDLE    2'd0
`define CPU_LSU_BYTE    2'd1
`define CPU_LSU_HWORD   2'd2
`define CPU_LSU_WORD    2'd3
`endif

module tb_memory_access;
  logic        clk = 1'b0;
  logic        nrst;
  logic        exec_stall, fetch_stall;
  logic [4:0]  rd_no;
  logic [31:0] alu;
  logic [1:0]  op;
  logic        lns, ext;
  logic [31:0] mdata;
  logic        mem_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_val;
  logic [31:0] baddr;
  logic        bcmd, bwr;
  logic [3:0]  bben;
  logic [31:0] bwdata;
  logic        ack, rvalid;
  logic [31:0] rdata;
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  memory_access dut (
    .clk(clk), .nrst(nrst), .i_exec_stall(exec_stall), .i_fetch_stall(fetch_stall),
    .i_rd_no(rd_no), .i_alu_result(alu), .i_lsu_op(op), .i_lsu_lns(lns), .i_lsu_ext(ext),
    .i_mem_data(mdata), .o_mem_stall(mem_stall),
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
    .o_addr_err(addr_err),
`endif
    .o_rd_no(o_rd), .o_rd_val(o_val), .o_bus_addr(baddr), .o_bus_cmd(bcmd), .o_bus_wr(bwr),
    .o_bus_ben(bben), .o_bus_wdata(bwdata), .i_bus_ack(ack), .i_bus_rdata(rdata),
    .i_bus_rdata_valid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        lns;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ack_dly;
    int          data_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_ben;
    logic [31:0] e_wdata;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    int          e_stall;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    op = `CPU_LSU_IDLE; lns = 1'b0; ext = 1'b0; alu = '0; rd_no = '0; mdata = '0;
    ack = 1'b0; rvalid = 1'b0; rdata = '0; exec_stall = 1'b0; fetch_stall = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   stall_n, cmd_n, wait_n, err_n;
    logic acked, done;

    // op lns ext addr wd rdata rd ackd datad | e_addr e_ben e_wdata e_wr e_rd e_val e_stall
    vq.push_back('{`CPU_LSU_IDLE, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0,
                   32'h0, 4'b0000, 32'h0, 1'b0, 5'd5, 32'h1234, 0});
    vq.push_back('{`CPU_LSU_BYTE, 1'b0, 1'b0, 32'h103, 32'hAB, 32'h0, 5'd7, 2, 0,
                   32'h100, 4'b1000, 32'hABABABAB, 1'b1, 5'd0, 32'h0, 4});
    vq.push_back('{`CPU_LSU_HWORD, 1'b1, 1'b1, 32'h202, 32'h0, 32'h80010000, 5'd3, 0, 1,
                   32'h200, 4'b1100, 32'h0, 1'b0, 5'd3, 32'hFFFF8001, 3});
    vq.push_back('{`CPU_LSU_HWORD, 1'b1, 1'b0, 32'h202, 32'h0, 32'h80010000, 5'd3, 0, 1,
                   32'h200, 4'b1100, 32'h0, 1'b0, 5'd3, 32'h00008001, 3});
    vq.push_back('{`CPU_LSU_WORD, 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 5'd9, 0, 0,
                   32'h400, 4'b1111, 32'h0, 1'b0, 5'd9, 32'hDEADBEEF, 2});
    vq.push_back('{`CPU_LSU_BYTE, 1'b1, 1'b1, 32'h501, 32'h0, 32'h0000F300, 5'd12, 1, 2,
                   32'h500, 4'b0010, 32'h0, 1'b0, 5'd12, 32'hFFFFFFF3, 5});
    vq.push_back('{`CPU_LSU_HWORD, 1'b0, 1'b0, 32'h206, 32'h1234BEEF, 32'h0, 5'd8, 0, 0,
                   32'h204, 4'b1100, 32'hBEEFBEEF, 1'b1, 5'd0, 32'h0, 2});
    vq.push_back('{`CPU_LSU_WORD, 1'b0, 1'b0, 32'h30C, 32'hCAFEF00D, 32'h0, 5'd10, 1, 0,
                   32'h30C, 4'b1111, 32'hCAFEF00D, 1'b1, 5'd0, 32'h0, 3});
    vq.push_back('{`CPU_LSU_BYTE, 1'b1, 1'b0, 32'h003, 32'h0, 32'h9A000000, 5'd2, 0, 0,
                   32'h000, 4'b1000, 32'h0, 1'b0, 5'd2, 32'h0000009A, 2});
`ifndef MEMORY_ACCESS_ALIGN_CHECK_EN
    vq.push_back('{`CPU_LSU_HWORD, 1'b1, 1'b0, 32'h203, 32'h0, 32'hABCD0000, 5'd4, 0, 0,
                   32'h200, 4'b1100, 32'h0, 1'b0, 5'd4, 32'h0000ABCD, 2});
`endif
    vq.push_back('{`CPU_LSU_IDLE, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd31, 0, 0,
                   32'h0, 4'b0000, 32'h0, 1'b0, 5'd31, 32'hFFFFFFFF, 0});

    idle_inputs();
    nrst = 1'b0;
    #12;
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_cmd", 32'(bcmd), 32'd0);
    chk("rst_rd_no", 32'(o_rd), 32'd0);
    chk("rst_rd_val", o_val, 32'd0);
    chk("rst_bus_addr", baddr, 32'd0);
    chk("rst_bus_ben", 32'(bben), 32'd0);
    chk("rst_bus_wr_wdata", {31'd0, bwr} | bwdata, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vq[i]) begin
      v = vq[i];
      @(posedge clk); #1;
      op = v.op; lns = v.lns; ext = v.ext; alu = v.addr; mdata = v.wd; rd_no = v.rd;
      rdata = v.rdata; ack = 1'b0; rvalid = 1'b0;
      stall_n = 0; cmd_n = 0; wait_n = 0; acked = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (!mem_stall) begin
          done = 1'b1;
          ack = 1'b0; rvalid = 1'b0;
        end else begin
          stall_n++;
          if (bcmd) begin
            cmd_n++;
            chk($sformatf("v%0d_bus_addr", i), baddr, v.e_addr);
            chk($sformatf("v%0d_bus_ben", i), 32'(bben), 32'(v.e_ben));
            chk($sformatf("v%0d_bus_wdata", i), bwdata, v.e_wdata);
            chk($sformatf("v%0d_bus_wr", i), 32'(bwr), 32'(v.e_wr));
            ack = (cmd_n > v.ack_dly);
            acked = acked | ack;
            rvalid = ack && v.lns && (v.data_dly == 0);
          end else if (acked) begin
            wait_n++;
            ack = 1'b0;
            rvalid = v.lns && (wait_n >= v.data_dly);
          end else begin
            ack = 1'b0; rvalid = 1'b0;
          end
        end
      end
      if (!done) begin
        n_checks++; n_errors++;
        $display("FAIL v%0d_timeout: got still-stalled expected done", i);
      end
      chk($sformatf("v%0d_stall_cycles", i), 32'(stall_n), 32'(v.e_stall));
      chk($sformatf("v%0d_cmd_cycles", i), 32'(cmd_n),
          (v.op == `CPU_LSU_IDLE) ? 32'd0 : 32'(v.ack_dly + 1));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rd_no", i), 32'(o_rd), 32'(v.e_rd));
      chk($sformatf("v%0d_rd_val", i), o_val, v.e_val);
      op = `CPU_LSU_IDLE; lns = 1'b0;
    end

    // Writeback must hold while either upstream stall is raised.
    @(posedge clk); #1;
    op = `CPU_LSU_IDLE; rd_no = 5'd4; alu = 32'h55; exec_stall = 1'b1;
    @(posedge clk); #1;
    chk("hold_exec_rd_no", 32'(o_rd), 32'd31);
    exec_stall = 1'b0; fetch_stall = 1'b1;
    @(posedge clk); #1;
    chk("hold_fetch_rd_val", o_val, 32'hFFFFFFFF);
    fetch_stall = 1'b0;
    @(posedge clk); #1;
    chk("release_rd_no", 32'(o_rd), 32'd4);
    chk("release_rd_val", o_val, 32'h55);

    // Reset in WAIT, then a stale response after release.
    op = `CPU_LSU_WORD; lns = 1'b1; alu = 32'h600; rd_no = 5'd9;
    done = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      @(negedge clk);
      if (bcmd) begin ack = 1'b1; done = 1'b1; end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL rst_seq_no_cmd: got no command expected command");
    end
    @(negedge clk);
    ack = 1'b0;
    chk("rst_seq_in_wait", {30'd0, mem_stall, bcmd}, 32'b10);
    idle_inputs();
    nrst = 1'b0;
    #2;
    chk("rst_seq_async_stall", 32'(mem_stall), 32'd0);
    chk("rst_seq_async_cmd", 32'(bcmd), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    rvalid = 1'b0;
    chk("rst_seq_stall", 32'(mem_stall), 32'd0);
    chk("rst_seq_cmd", 32'(bcmd), 32'd0);
    chk("rst_seq_rd_val", o_val, 32'd0);
    @(negedge clk);
    chk("rst_seq_stall_later", 32'(mem_stall), 32'd0);

`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
    // Misaligned word load: no bus command, single error pulse, writeback to R0.
    @(posedge clk); #1;
    rd_no = 5'd31; alu = 32'h77;
    @(posedge clk); #1;
    op = `CPU_LSU_WORD; lns = 1'b1; alu = 32'h301; rd_no = 5'd6;
    cmd_n = 0; err_n = 0; done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bcmd) cmd_n++;
      if (addr_err) err_n++;
      if (!mem_stall && !done) begin
        done = 1'b1;
        @(posedge clk); #1;
        chk("align_rd_no", 32'(o_rd), 32'd0);
        op = `CPU_LSU_IDLE; lns = 1'b0;
      end
    end
    chk("align_done_seen", 32'(done), 32'd1);
    chk("align_cmd_cycles", 32'(cmd_n), 32'd0);
    chk("align_err_pulses", 32'(err_n), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
